// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the fetch stage
//
// Purpose: state encoding and width/address defaults used by the fetch
// sequencer and by any stage that shares the branch target calculator.
// Ports: none (package).

package fetch_pkg;

    // Sequencer states. REDIRECT is the one-cycle bubble that follows a taken
    // branch while the target address is presented to the ROM.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALTED   = 2'd3
    } fetch_state_t;

    localparam int unsigned PC_W_DEF     = 16;
    localparam int unsigned RESET_PC_DEF = 0;
    localparam int unsigned CNT_W_DEF    = 16;

    // Width of one instruction word held in the ROM.
    localparam int unsigned INSTR_W = 9;

endpackage

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - combinational branch target adder/subtractor
//
// Purpose: computes br_pc +/- br_offset modulo 2^PC_W. Shared by the fetch
// sequencer and the execute stage so both agree on the redirect address.
// Ports:
//   br_pc_i      branch instruction PC
//   br_offset_i  unsigned branch distance
//   br_sign_i    1 = forward (add), 0 = backward (subtract)
//   target_o     resulting fetch address

module branch_target_calc #(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] br_pc_i,
    input  logic [PC_W-1:0] br_offset_i,
    input  logic            br_sign_i,
    output logic [PC_W-1:0] target_o
);

    // Both arms truncate to PC_W, giving the required wraparound.
    always_comb begin
        if (br_sign_i) begin
            target_o = br_pc_i + br_offset_i;
        end else begin
            target_o = br_pc_i - br_offset_i;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter owner and fetch stage sequencer
//
// Purpose: launches execution on start, advances the PC on unstalled RUN
// cycles, redirects on taken branches through a one-cycle REDIRECT bubble
// with a flush pulse, and parks in HALTED on a decoded halt.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             launch/restart pulse
//   stall             decode hazard stall, holds PC and fetch counter
//   halt_req          halt instruction decoded
//   br_valid/br_taken branch resolved / outcome
//   br_sign           1 = forward, 0 = backward
//   br_pc, br_offset  resolving branch PC and unsigned distance
//   pc                registered ROM fetch address
//   if_valid          pc is on the correct path (RUN only)
//   flush             one-cycle squash of IF/ID and ID/EX
//   running           state is RUN or REDIRECT
//   done              state is HALTED
//   fetch_count       saturating count of fetches since last launch

module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
    parameter int              CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic              br_sign,
    input  logic [PC_W-1:0]   br_pc,
    input  logic [PC_W-1:0]   br_offset,
    output logic [PC_W-1:0]   pc,
    output logic              if_valid,
    output logic              flush,
    output logic              running,
    output logic              done,
    output logic [CNT_W-1:0]  fetch_count
);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             if_valid_q, if_valid_d;
    logic             flush_q, flush_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    logic [PC_W-1:0]  br_target;
    logic             br_redirect;
    logic [CNT_W-1:0] cnt_inc;

    branch_target_calc #(
        .PC_W (PC_W)
    ) u_target (
        .br_pc_i     (br_pc),
        .br_offset_i (br_offset),
        .br_sign_i   (br_sign),
        .target_o    (br_target)
    );

    assign br_redirect = br_valid && br_taken;

    // Saturating increment: the counter sticks at all-ones.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        flush_d = 1'b0;

        if (start) begin
            state_d = ST_RUN;
            pc_d    = RESET_PC;
            cnt_d   = '0;
            // Restarting an active pipeline must discard in-flight work;
            // launching from IDLE/HALTED has nothing to discard.
            flush_d = (state_q == ST_RUN) || (state_q == ST_REDIRECT);
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (br_redirect) begin
                        // Stall and halt arrive from wrong-path instructions
                        // and are dropped in favour of the redirect.
                        state_d = ST_REDIRECT;
                        pc_d    = br_target;
                        flush_d = 1'b1;
                    end else begin
                        if (!stall) begin
                            cnt_d = cnt_inc;
                        end
                        if (halt_req) begin
                            state_d = ST_HALTED;
                        end else if (!stall) begin
                            pc_d = pc_q + PC_W'(1);
                        end
                    end
                end
                ST_REDIRECT: begin
                    if (br_redirect) begin
                        pc_d    = br_target;
                        flush_d = 1'b1;
                    end else begin
                        // Target is held so it is fetched with if_valid=1.
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    // IDLE and HALTED respond only to start.
                end
            endcase
        end

        // Status outputs are registered from the next state so they line up
        // with the pc they qualify.
        if_valid_d = (state_d == ST_RUN);
        running_d  = (state_d == ST_RUN) || (state_d == ST_REDIRECT);
        done_d     = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            cnt_q      <= '0;
            if_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            if_valid_q <= if_valid_d;
            flush_q    <= flush_d;
            running_q  <= running_d;
            done_q     <= done_d;
        end
    end

    assign pc          = pc_q;
    assign if_valid    = if_valid_q;
    assign flush       = flush_q;
    assign running     = running_q;
    assign done        = done_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed table-driven bench for fetch_sequencer

module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start, stall, halt_req, br_valid, br_taken, br_sign;
    logic [15:0] br_pc, br_offset;
    logic [15:0] pc;
    logic        if_valid, flush, running, done;
    logic [3:0]  fetch_count;

    int tests;
    int fails;

    fetch_sequencer #(
        .PC_W     (16),
        .RESET_PC (16'h0000),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .halt_req    (halt_req),
        .br_valid    (br_valid),
        .br_taken    (br_taken),
        .br_sign     (br_sign),
        .br_pc       (br_pc),
        .br_offset   (br_offset),
        .pc          (pc),
        .if_valid    (if_valid),
        .flush       (flush),
        .running     (running),
        .done        (done),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        st, stl, hlt, bv, bt, bs;
        logic [15:0] bpc, boff;
        logic [15:0] epc;
        logic        eiv, efl, erun, edone;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic st, logic stl, logic hlt,
                                logic bv, logic bt, logic bs,
                                logic [15:0] bpc, logic [15:0] boff,
                                logic [15:0] epc, logic eiv, logic efl,
                                logic erun, logic edone, logic [3:0] ecnt);
        vec_t v;
        v.name = n; v.st = st; v.stl = stl; v.hlt = hlt;
        v.bv = bv; v.bt = bt; v.bs = bs; v.bpc = bpc; v.boff = boff;
        v.epc = epc; v.eiv = eiv; v.efl = efl; v.erun = erun;
        v.edone = edone; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] epc, input logic eiv,
                             input logic efl, input logic erun, input logic edone,
                             input logic [3:0] ecnt);
        chk({tag, ".pc"},       32'(pc),          32'(epc));
        chk({tag, ".if_valid"}, 32'(if_valid),    32'(eiv));
        chk({tag, ".flush"},    32'(flush),       32'(efl));
        chk({tag, ".running"},  32'(running),     32'(erun));
        chk({tag, ".done"},     32'(done),        32'(edone));
        chk({tag, ".count"},    32'(fetch_count), 32'(ecnt));
    endtask

    task automatic drive(input logic st, input logic stl, input logic hlt, input logic bv,
                         input logic bt, input logic bs, input logic [15:0] bpc,
                         input logic [15:0] boff);
        start = st; stall = stl; halt_req = hlt;
        br_valid = bv; br_taken = bt; br_sign = bs;
        br_pc = bpc; br_offset = boff;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);

        //        name          st stl hlt bv bt bs  bpc      boff     | pc      iv fl run dn cnt
        vecs.push_back(mk("idle",      0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'd0));
        vecs.push_back(mk("idle_br",   0, 0, 0, 1, 1, 1, 16'h0004, 16'h0003, 16'h0000, 0, 0, 0, 0, 4'd0));
        vecs.push_back(mk("start",     1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 0, 4'd0));
        vecs.push_back(mk("adv1",      0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 1, 0, 1, 0, 4'd1));
        vecs.push_back(mk("adv2",      0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0002, 1, 0, 1, 0, 4'd2));
        vecs.push_back(mk("adv3",      0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0003, 1, 0, 1, 0, 4'd3));
        vecs.push_back(mk("adv4",      0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0004, 1, 0, 1, 0, 4'd4));
        vecs.push_back(mk("ntaken",    0, 0, 0, 1, 0, 1, 16'h0004, 16'h0003, 16'h0005, 1, 0, 1, 0, 4'd5));
        vecs.push_back(mk("stall1",    0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0005, 1, 0, 1, 0, 4'd5));
        vecs.push_back(mk("stall2",    0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0005, 1, 0, 1, 0, 4'd5));
        vecs.push_back(mk("release",   0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0006, 1, 0, 1, 0, 4'd6));
        vecs.push_back(mk("fwd_br",    0, 1, 1, 1, 1, 1, 16'h0004, 16'h0003, 16'h0007, 0, 1, 1, 0, 4'd6));
        vecs.push_back(mk("redir_out", 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0007, 1, 0, 1, 0, 4'd6));
        vecs.push_back(mk("tgt_p1",    0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0008, 1, 0, 1, 0, 4'd7));
        vecs.push_back(mk("adv9",      0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0009, 1, 0, 1, 0, 4'd8));
        vecs.push_back(mk("halt",      0, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0009, 0, 0, 0, 1, 4'd8));
        vecs.push_back(mk("halted",    0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0009, 0, 0, 0, 1, 4'd8));
        vecs.push_back(mk("halted_br", 0, 1, 1, 1, 1, 1, 16'h0010, 16'h0010, 16'h0009, 0, 0, 0, 1, 4'd8));
        vecs.push_back(mk("restart",   1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 0, 4'd0));
        vecs.push_back(mk("r_adv1",    0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 1, 0, 1, 0, 4'd1));
        vecs.push_back(mk("back_br",   0, 0, 0, 1, 1, 0, 16'h0002, 16'h0005, 16'hFFFD, 0, 1, 1, 0, 4'd1));
        vecs.push_back(mk("redir_br",  0, 0, 0, 1, 1, 1, 16'hFFFA, 16'h0004, 16'hFFFE, 0, 1, 1, 0, 4'd1));
        vecs.push_back(mk("redir_end", 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'hFFFE, 1, 0, 1, 0, 4'd1));
        vecs.push_back(mk("adv_ffff",  0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'hFFFF, 1, 0, 1, 0, 4'd2));
        vecs.push_back(mk("wrap",      0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 0, 4'd3));
        vecs.push_back(mk("run_start", 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 1, 0, 4'd0));
        vecs.push_back(mk("post_rst",  0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 1, 0, 1, 0, 4'd1));

        #3;
        check_out("reset", 16'h0000, 0, 0, 0, 0, 4'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].stl, vecs[i].hlt, vecs[i].bv, vecs[i].bt,
                  vecs[i].bs, vecs[i].bpc, vecs[i].boff);
            @(posedge clk);
            #1;
            check_out(vecs[i].name, vecs[i].epc, vecs[i].eiv, vecs[i].efl,
                      vecs[i].erun, vecs[i].edone, vecs[i].ecnt);
        end

        // Counter saturation: 14 more advances take count from 1 to 15.
        drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
        end
        check_out("sat_reach", 16'h000F, 1, 0, 1, 0, 4'd15);
        @(posedge clk);
        #1;
        check_out("sat_hold", 16'h0010, 1, 0, 1, 0, 4'd15);

        // Asynchronous reset in the middle of a REDIRECT bubble.
        drive(0, 0, 0, 1, 1, 1, 16'h0100, 16'h0020);
        @(posedge clk);
        #1;
        check_out("pre_rst_redir", 16'h0120, 0, 1, 1, 0, 4'd15);
        drive(1, 0, 0, 1, 1, 1, 16'h0100, 16'h0020);
        #2 rst_n = 1'b0;
        #1;
        check_out("async_rst", 16'h0000, 0, 0, 0, 0, 4'd0);
        @(posedge clk);
        #1;
        check_out("rst_held", 16'h0000, 0, 0, 0, 0, 4'd0);
        drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("idle_after1", 16'h0000, 0, 0, 0, 0, 4'd0);
        drive(0, 1, 1, 1, 1, 1, 16'h0040, 16'h0001);
        @(posedge clk);
        #1;
        check_out("idle_after2", 16'h0000, 0, 0, 0, 0, 4'd0);
        drive(1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        check_out("start_after_rst", 16'h0000, 1, 0, 1, 0, 4'd0);
        drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        check_out("adv_after_rst", 16'h0001, 1, 0, 1, 0, 4'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
